// File: rtl/fsm_pkg.sv
// Shared definitions for the 4-state FSM block, its sequencer and the benches.
package fsm_pkg;

    typedef logic [3:0] fsm_state_t;

    localparam fsm_state_t FSM_S1 = 4'b0001;
    localparam fsm_state_t FSM_S2 = 4'b0010;
    localparam fsm_state_t FSM_S3 = 4'b0100;
    localparam fsm_state_t FSM_S4 = 4'b1000;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_SEL,
        SEQ_GAP1,
        SEQ_P12,
        SEQ_WAIT_S2,
        SEQ_GAP2,
        SEQ_P23,
        SEQ_WAIT_S4,
        SEQ_GAP3,
        SEQ_P41,
        SEQ_WAIT_S1,
        SEQ_DONE
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fsm_seq_if.sv
// Control bus between the sequencer (master) and the FSM block (slave).
interface fsm_seq_if;
    import fsm_pkg::*;

    logic       i_sel;
    logic       i_sel_valid;
    logic       state1_to_state2;
    logic       state2_to_state3;
    logic       state4_to_state1;
    fsm_state_t state_fb;
    logic [7:0] i_data1;
    logic [7:0] i_data2;

    modport master (
        output i_sel, i_sel_valid, state1_to_state2, state2_to_state3, state4_to_state1,
        input  state_fb, i_data1, i_data2
    );

    modport slave (
        input  i_sel, i_sel_valid, state1_to_state2, state2_to_state3, state4_to_state1,
        output state_fb, i_data1, i_data2
    );
endinterface

// File: rtl/fsm_seq_timer.sv
// Loadable down-counter that stops at zero; tc flags the terminal count.
module fsm_seq_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);
endmodule

// File: rtl/fsm_seq.sv
// Sequencer driving the select handshake and transition pulses of the FSM block,
// checking state feedback, capturing S4 data and flagging timeouts.
module fsm_seq
    import fsm_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_sel_cfg,
    fsm_seq_if.master  bus,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_cap_data1,
    output logic [7:0] o_cap_data2,
    output logic       o_cap_valid
);
    localparam int CNT_W = $clog2(max_int(GAP_CYCLES, TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT - 1);

    seq_state_t       state_q, state_d;
    logic             sel_q, sel_d;
    logic             err_q, err_d;
    logic             cap_valid_q, cap_valid_d;
    logic [7:0]       cap1_q, cap1_d;
    logic [7:0]       cap2_q, cap2_d;
    fsm_state_t       target;
    logic             in_wait;
    logic             fb_match;
    logic             timed_out;
    logic             tmr_load;
    logic             tmr_tc;
    logic [CNT_W-1:0] tmr_load_val;

    // Timer reloads on every state change: GAP length, wait window, or cleared.
    fsm_seq_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        target  = FSM_S1;
        in_wait = 1'b0;
        case (state_q)
            SEQ_WAIT_S2: begin target = FSM_S2; in_wait = 1'b1; end
            SEQ_WAIT_S4: begin target = FSM_S4; in_wait = 1'b1; end
            SEQ_WAIT_S1: begin target = FSM_S1; in_wait = 1'b1; end
            default: ;
        endcase
        fb_match  = in_wait && (bus.state_fb == target);
        timed_out = in_wait && !fb_match && tmr_tc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:    if (i_start) state_d = SEQ_SEL;
            SEQ_SEL:     state_d = SEQ_GAP1;
            SEQ_GAP1:    if (tmr_tc) state_d = SEQ_P12;
            SEQ_P12:     state_d = SEQ_WAIT_S2;
            SEQ_WAIT_S2: if (fb_match) state_d = SEQ_GAP2; else if (timed_out) state_d = SEQ_IDLE;
            SEQ_GAP2:    if (tmr_tc) state_d = SEQ_P23;
            SEQ_P23:     state_d = SEQ_WAIT_S4;
            SEQ_WAIT_S4: if (fb_match) state_d = SEQ_GAP3; else if (timed_out) state_d = SEQ_IDLE;
            SEQ_GAP3:    if (tmr_tc) state_d = SEQ_P41;
            SEQ_P41:     state_d = SEQ_WAIT_S1;
            SEQ_WAIT_S1: if (fb_match) state_d = SEQ_DONE; else if (timed_out) state_d = SEQ_IDLE;
            SEQ_DONE:    state_d = SEQ_IDLE;
            default:     state_d = SEQ_IDLE;
        endcase
    end

    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            SEQ_GAP1, SEQ_GAP2, SEQ_GAP3:          tmr_load_val = GAP_LOAD;
            SEQ_WAIT_S2, SEQ_WAIT_S4, SEQ_WAIT_S1: tmr_load_val = WAIT_LOAD;
            default:                               tmr_load_val = '0;
        endcase
    end

    // Moore outputs: each strobe belongs to exactly one state, so they never overlap.
    always_comb begin
        bus.i_sel_valid      = 1'b0;
        bus.state1_to_state2 = 1'b0;
        bus.state2_to_state3 = 1'b0;
        bus.state4_to_state1 = 1'b0;
        o_done               = 1'b0;
        case (state_q)
            SEQ_SEL:  bus.i_sel_valid      = 1'b1;
            SEQ_P12:  bus.state1_to_state2 = 1'b1;
            SEQ_P23:  bus.state2_to_state3 = 1'b1;
            SEQ_P41:  bus.state4_to_state1 = 1'b1;
            SEQ_DONE: o_done               = 1'b1;
            default: ;
        endcase
        o_busy = (state_q != SEQ_IDLE);
    end

    always_comb begin
        sel_d       = sel_q;
        err_d       = err_q;
        cap1_d      = cap1_q;
        cap2_d      = cap2_q;
        cap_valid_d = 1'b0;
        if (state_q == SEQ_IDLE && i_start) begin
            sel_d = i_sel_cfg;
            err_d = 1'b0;
        end
        if (timed_out) begin
            err_d = 1'b1;
        end
        if (state_q == SEQ_WAIT_S4 && fb_match) begin
            cap1_d      = bus.i_data1;
            cap2_d      = bus.i_data2;
            cap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= 1'b0;
            err_q       <= 1'b0;
            cap1_q      <= 8'h00;
            cap2_q      <= 8'h00;
            cap_valid_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            err_q       <= err_d;
            cap1_q      <= cap1_d;
            cap2_q      <= cap2_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign bus.i_sel   = sel_q;
    assign o_err       = err_q;
    assign o_cap_data1 = cap1_q;
    assign o_cap_data2 = cap2_q;
    assign o_cap_valid = cap_valid_q;
endmodule

// File: tb/tb_fsm_seq.sv
// Bench for fsm_seq: behavioural FSM model on the bus, vector table with a
// result scoreboard, and hand-written reset / held-start sequences.
module tb_fsm_seq;
    import fsm_pkg::*;

    localparam int G = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_sel_cfg = 1'b0;
    logic       o_busy, o_done, o_err, o_cap_valid;
    logic [7:0] o_cap_data1, o_cap_data2;

    fsm_seq_if bus();

    fsm_seq #(.GAP_CYCLES(G), .TIMEOUT(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_sel_cfg   (i_sel_cfg),
        .bus         (bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_cap_data1 (o_cap_data1),
        .o_cap_data2 (o_cap_data2),
        .o_cap_valid (o_cap_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int cur_idx = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur_idx, act, exp);
        end
    endtask

    // Behavioural FSM: S1->S2 after m_dly extra cycles, S3->S4 on its own.
    fsm_state_t m_state;
    fsm_state_t m_tgt;
    int         m_cnt;
    bit         m_pend;
    int         m_dly = 0;
    bit         m_freeze = 1'b0;
    logic [7:0] m_d1 = 8'h00;
    logic [7:0] m_d2 = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_state <= FSM_S1;
            m_tgt   <= FSM_S1;
            m_pend  <= 1'b0;
            m_cnt   <= 0;
        end else if (m_pend) begin
            if (m_cnt == 0) begin
                m_state <= m_tgt;
                m_pend  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else begin
            case (m_state)
                FSM_S1: if (bus.state1_to_state2 && !m_freeze) begin
                    if (m_dly == 0) m_state <= FSM_S2;
                    else begin m_pend <= 1'b1; m_cnt <= m_dly - 1; m_tgt <= FSM_S2; end
                end
                FSM_S2: if (bus.state2_to_state3) m_state <= FSM_S3;
                FSM_S3: begin m_pend <= 1'b1; m_cnt <= 1; m_tgt <= FSM_S4; end
                FSM_S4: if (bus.state4_to_state1) m_state <= FSM_S1;
                default: m_state <= FSM_S1;
            endcase
        end
    end

    assign bus.state_fb = m_state;
    assign bus.i_data1  = (m_state == FSM_S4) ? m_d1 : 8'h00;
    assign bus.i_data2  = (m_state == FSM_S4) ? m_d2 : 8'h00;

    typedef struct {
        bit         sel;
        int         dly;
        bit         freeze;
        bit         poke;
        logic [7:0] d1;
        logic [7:0] d2;
    } vec_t;

    typedef struct {
        bit         err;
        bit         sel;
        logic [7:0] c1;
        logic [7:0] c2;
    } exp_t;

    exp_t sb[$];

    task automatic run_vec(input int idx, input vec_t v);
        int t0, rel, post;
        int sv_c, p12_c, p23_c, p41_c, s2_c, s4_c, s1_c, cap_c, done_c, err_c;
        int n_sv, n_done, multi;
        logic busy_at_err;
        logic [7:0] cap1, cap2;
        exp_t e;
        sv_c = -1; p12_c = -1; p23_c = -1; p41_c = -1; s2_c = -1; s4_c = -1;
        s1_c = -1; cap_c = -1; done_c = -1; err_c = -1;
        n_sv = 0; n_done = 0; multi = 0; post = -1; busy_at_err = 1'b1;
        cap1 = 8'h00; cap2 = 8'h00;
        cur_idx = idx;
        m_dly = v.dly; m_freeze = v.freeze; m_d1 = v.d1; m_d2 = v.d2;
        @(negedge clk);
        i_start = 1'b1;
        i_sel_cfg = v.sel;
        e.err = v.freeze; e.sel = v.sel; e.c1 = v.d1; e.c2 = v.d2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        t0 = cyc;
        i_start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            rel = cyc - t0 + 1;
            if (rel == 1) check("err_cleared_by_start", o_err, 0);
            if ((int'(bus.i_sel_valid) + int'(bus.state1_to_state2) +
                 int'(bus.state2_to_state3) + int'(bus.state4_to_state1)) > 1) multi++;
            if (bus.i_sel_valid) begin n_sv++; if (sv_c < 0) sv_c = rel; end
            if (bus.state1_to_state2 && p12_c < 0) p12_c = rel;
            if (p12_c > 0 && s2_c < 0 && m_state == FSM_S2) s2_c = rel;
            if (bus.state2_to_state3 && p23_c < 0) p23_c = rel;
            if (m_state == FSM_S4 && s4_c < 0) s4_c = rel;
            if (bus.state4_to_state1 && p41_c < 0) p41_c = rel;
            if (p41_c > 0 && s1_c < 0 && m_state == FSM_S1) s1_c = rel;
            if (o_cap_valid && cap_c < 0) begin cap_c = rel; cap1 = o_cap_data1; cap2 = o_cap_data2; end
            if (o_done) begin n_done++; if (done_c < 0) done_c = rel; end
            if (o_err && err_c < 0) begin err_c = rel; busy_at_err = o_busy; end
            if (v.poke && s2_c > 0 && rel == s2_c + 2) begin
                i_start = 1'b1;
                i_sel_cfg = ~v.sel;
            end else begin
                i_start = 1'b0;
            end
            if (post < 0 && (done_c > 0 || err_c > 0)) post = 4;
            if (post > 0) post--;
            if (post == 0) break;
        end
        check("sequence_end_seen", (done_c > 0 || err_c > 0), 1);
        e = sb.pop_front();
        check("err_flag", (err_c > 0), e.err);
        check("n_sel_valid", n_sv, 1);
        check("sel_valid_cycle", sv_c, 1);
        check("p12_cycle", p12_c, 2 + G);
        check("pulses_exclusive", multi, 0);
        if (e.err) begin
            check("err_cycle", err_c, p12_c + T + 1);
            check("busy_at_err", busy_at_err, 0);
            check("no_done_on_err", n_done, 0);
        end else begin
            check("p23_after_s2", p23_c, s2_c + G + 1);
            check("p41_after_s4", p41_c, s4_c + G + 1);
            check("cap_valid_cycle", cap_c, s4_c + 1);
            check("cap_data1", cap1, e.c1);
            check("cap_data2", cap2, e.c2);
            check("done_cycle", done_c, s1_c + 1);
            check("n_done", n_done, 1);
            check("i_sel_kept", bus.i_sel, e.sel);
        end
        $display("vec %0d: sel=%0d dly=%0d freeze=%0d poke=%0d -> p12@%0d s2@%0d p23@%0d s4@%0d done@%0d err@%0d cap=%0h/%0h",
                 idx, v.sel, v.dly, v.freeze, v.poke, p12_c, s2_c, p23_c, s4_c, done_c, err_c, cap1, cap2);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        check(name, seen, 1);
    endtask

    function automatic logic [24:0] out_vec();
        return {bus.i_sel, bus.i_sel_valid, bus.state1_to_state2, bus.state2_to_state3,
                bus.state4_to_state1, o_busy, o_done, o_err, o_cap_valid, o_cap_data1, o_cap_data2};
    endfunction

    initial begin
        vec_t vecs[5];
        bit   seen;
        vecs[0] = '{sel: 1'b1, dly: 0,     freeze: 1'b0, poke: 1'b0, d1: 8'hA5, d2: 8'h3C};
        vecs[1] = '{sel: 1'b0, dly: 3,     freeze: 1'b0, poke: 1'b0, d1: 8'h5A, d2: 8'hC3};
        vecs[2] = '{sel: 1'b1, dly: T - 1, freeze: 1'b0, poke: 1'b0, d1: 8'h11, d2: 8'h22};
        vecs[3] = '{sel: 1'b0, dly: 0,     freeze: 1'b1, poke: 1'b0, d1: 8'h00, d2: 8'h00};
        vecs[4] = '{sel: 1'b1, dly: 0,     freeze: 1'b0, poke: 1'b1, d1: 8'h77, d2: 8'h88};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", out_vec(), 25'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", out_vec(), 25'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // i_start held high: a new sequence begins on the first IDLE cycle after DONE.
        cur_idx = 5;
        m_freeze = 1'b0; m_dly = 0;
        @(negedge clk);
        i_start = 1'b1;
        i_sel_cfg = 1'b0;
        wait_done("hold_first_done");
        @(negedge clk);
        check("hold_idle_gap", o_busy, 0);
        @(negedge clk);
        check("hold_restart", bus.i_sel_valid, 1);
        i_start = 1'b0;
        wait_done("hold_second_done");
        $display("vec 5: held start, back-to-back sequences, i_sel=%0d", bus.i_sel);

        // Reset asserted while state2_to_state3 is high.
        cur_idx = 6;
        @(negedge clk);
        i_start = 1'b1;
        i_sel_cfg = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (bus.state2_to_state3) seen = 1'b1;
        end
        check("p23_reached", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_p23_cut", bus.state2_to_state3, 0);
        check("rst_busy", o_busy, 0);
        check("rst_all_outputs", out_vec(), 25'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_busy) seen = 1'b1;
        end
        check("no_pending_start", seen, 0);
        $display("vec 6: reset during P23, outputs=%0h", out_vec());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
